// File: rtl/key_evt_pkg.sv
// Shared types and sizes for the key debounce / auto-repeat event queue.
package key_evt_pkg;

  localparam int unsigned EVT_W      = 5;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CNT_W      = 11;
  localparam int unsigned IDX_W      = 3;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    PRESS   = 2'd1,
    REPEAT  = 2'd2,
    RELEASE = 2'd3
  } evt_type_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    HELD     = 3'd2,
    RPT      = 3'd3,
    REL_DB   = 3'd4
  } key_fsm_e;

  // Event payload as seen by the consumer: {type, key index}
  typedef struct packed {
    evt_type_e              typ;
    logic [IDX_W-1:0]       idx;
  } evt_t;

  function automatic evt_t make_evt(input evt_type_e typ, input logic [IDX_W-1:0] idx);
    evt_t e;
    e.typ = typ;
    e.idx = idx;
    return e;
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Depth-4 first-word-fall-through FIFO; head entry is always r_mem[0].
module key_evt_fifo
  import key_evt_pkg::*;
#(
  parameter int unsigned W = EVT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready_c,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IW = $clog2(FIFO_DEPTH);

  logic [W-1:0]  r_mem     [FIFO_DEPTH];
  logic [W-1:0]  w_mem_nxt [FIFO_DEPTH];
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          r_valid;
  logic          w_push;
  logic          w_pop;
  logic [IW-1:0] w_wr_idx;

  // A full FIFO still accepts a write when the head leaves in the same cycle
  assign o_ready_c = (r_count != CW'(FIFO_DEPTH)) || i_ready;
  assign w_pop     = r_valid & i_ready;
  assign w_push    = i_valid & o_ready_c;
  assign w_wr_idx  = IW'(r_count - CW'(w_pop));
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  // Shift down on pop, then write the new entry behind the last valid one
  always_comb begin
    for (int j = 0; j < FIFO_DEPTH; j++) w_mem_nxt[j] = r_mem[j];
    if (w_pop) begin
      for (int j = 0; j < FIFO_DEPTH - 1; j++) w_mem_nxt[j] = r_mem[j + 1];
    end
    if (w_push) w_mem_nxt[w_wr_idx] = i_data;
  end

  // Storage, occupancy and registered valid flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < FIFO_DEPTH; j++) r_mem[j] <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      for (int j = 0; j < FIFO_DEPTH; j++) r_mem[j] <= w_mem_nxt[j];
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_mem[0];

endmodule

// File: rtl/key_event_queue.sv
// Per-key debounce, hold and auto-repeat engine feeding a PRESS/REPEAT/RELEASE event queue.
module key_event_queue
  import key_evt_pkg::*;
#(
  parameter int unsigned F_CLK       = 50_000_000,
  parameter int unsigned N_KEYS      = 6,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned HOLD_MS     = 500,
  parameter int unsigned REPEAT_MS   = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_state,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [EVT_W-1:0]  evt_data,
  output logic              overflow
);

  localparam int unsigned TICK_DIV = F_CLK / 1000;
  localparam int unsigned PRE_W    = $clog2(TICK_DIV);

  logic [PRE_W-1:0]  r_presc;
  logic              w_tick;
  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;
  logic [N_KEYS-1:0] w_post;
  evt_type_e         w_post_type [N_KEYS];
  evt_type_e         r_pend      [N_KEYS];
  logic              r_overflow;
  logic              w_arb_valid;
  logic [IDX_W-1:0]  w_arb_idx;
  evt_type_e         w_arb_type;
  evt_t              w_push_data;
  logic              w_fifo_ready_c;
  logic              w_push;
  logic [N_KEYS-1:0] w_free;
  logic [N_KEYS-1:0] w_ovf;

  assign w_tick = (r_presc == PRE_W'(TICK_DIV - 1));

  // 1 ms tick prescaler shared by all keys
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PRE_W'(1);
  end

  // Two-flop synchronizer; idles released so reset never looks like a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= key;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_fsm_e         r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ks;
    logic             r_post;
    evt_type_e        r_post_type;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // Debounce / hold / repeat state machine; r_post is a one-cycle post strobe
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state     <= IDLE;
        r_cnt       <= '0;
        r_ks        <= 1'b1;
        r_post      <= 1'b0;
        r_post_type <= NONE;
      end else begin
        r_post <= 1'b0;
        case (r_state)
          IDLE: begin
            if (!r_sync2[g]) begin
              r_state <= PRESS_DB;
              r_cnt   <= '0;
            end
          end
          PRESS_DB: begin
            if (r_sync2[g]) begin
              r_state <= IDLE;
            end else if (w_tick) begin
              if (w_cnt_inc == CNT_W'(DEBOUNCE_MS)) begin
                r_state     <= HELD;
                r_cnt       <= '0;
                r_ks        <= 1'b0;
                r_post      <= 1'b1;
                r_post_type <= PRESS;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end
          end
          HELD: begin
            if (r_sync2[g]) begin
              r_state <= REL_DB;
              r_cnt   <= '0;
            end else if (w_tick) begin
              if (w_cnt_inc == CNT_W'(HOLD_MS)) begin
                r_state     <= RPT;
                r_cnt       <= '0;
                r_post      <= 1'b1;
                r_post_type <= REPEAT;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end
          end
          RPT: begin
            if (r_sync2[g]) begin
              r_state <= REL_DB;
              r_cnt   <= '0;
            end else if (w_tick) begin
              if (w_cnt_inc == CNT_W'(REPEAT_MS)) begin
                r_cnt       <= '0;
                r_post      <= 1'b1;
                r_post_type <= REPEAT;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end
          end
          REL_DB: begin
            if (!r_sync2[g]) begin
              r_state <= HELD;
              r_cnt   <= '0;
            end else if (w_tick) begin
              if (w_cnt_inc == CNT_W'(DEBOUNCE_MS)) begin
                r_state     <= IDLE;
                r_cnt       <= '0;
                r_ks        <= 1'b1;
                r_post      <= 1'b1;
                r_post_type <= RELEASE;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end

    assign w_post[g]      = r_post;
    assign w_post_type[g] = r_post_type;
    assign key_state[g]   = r_ks;
  end

  // Lowest-index occupied pending register wins the single push slot
  always_comb begin
    w_arb_valid = 1'b0;
    w_arb_idx   = '0;
    w_arb_type  = NONE;
    for (int i = int'(N_KEYS) - 1; i >= 0; i--) begin
      if (r_pend[i] != NONE) begin
        w_arb_valid = 1'b1;
        w_arb_idx   = IDX_W'(i);
        w_arb_type  = r_pend[i];
      end
    end
  end

  assign w_push      = w_arb_valid & w_fifo_ready_c;
  assign w_push_data = make_evt(w_arb_type, w_arb_idx);

  // A post only overflows when it lands on an entry that is not leaving this cycle
  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      w_free[i] = w_push && (w_arb_idx == IDX_W'(i));
      w_ovf[i]  = w_post[i] && (r_pend[i] != NONE) && !w_free[i];
    end
  end

  // Pending registers and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_KEYS; i++) r_pend[i] <= NONE;
      r_overflow <= 1'b0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (w_post[i])      r_pend[i] <= w_post_type[i];
        else if (w_free[i]) r_pend[i] <= NONE;
      end
      r_overflow <= r_overflow | (|w_ovf);
    end
  end

  key_evt_fifo #(
    .W (EVT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (w_arb_valid),
    .o_ready_c (w_fifo_ready_c),
    .i_data    (w_push_data),
    .o_valid   (evt_valid),
    .i_ready   (evt_ready),
    .o_data    (evt_data)
  );

  assign overflow = r_overflow;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue: 10-cycle tick, debounce 2, hold 5, repeat 3.
`timescale 1ns/1ps
module tb_key_event_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] key;
  logic [5:0] key_state;
  logic       evt_valid;
  logic       evt_ready;
  logic [4:0] evt_data;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [4:0] ev_d [$];
  int         ev_t [$];

  key_event_queue #(
    .F_CLK       (10_000),
    .N_KEYS      (6),
    .DEBOUNCE_MS (2),
    .HOLD_MS     (5),
    .REPEAT_MS   (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .key_state (key_state),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_data  (evt_data),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Edges since reset release; tick edges are the multiples of 10
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Record every accepted event with the edge count it was visible at
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      ev_d.push_back(evt_data);
      ev_t.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // Put the bench at edge count == 2 mod 10 so key falls land mid-tick-period
  task automatic align();
    repeat (10) if (cyc % 10 != 2) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key = '1;
    evt_ready = 1'b1;
    steps(3);
    n_cmp++; if (key_state !== 6'h3F) begin n_bad++; $display("FAIL reset_key_state: got %h want %h", key_state, 6'h3F); end
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL reset_evt_valid: got %b want 0", evt_valid); end
    n_cmp++; if (evt_data !== 5'd0) begin n_bad++; $display("FAIL reset_evt_data: got %b want 00000", evt_data); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    rst = 1'b0;
  endtask

  task automatic test_bounce();
    ev_d.delete(); ev_t.delete();
    align();
    key[0] = 1'b0;
    steps(10);
    n_cmp++; if (key_state !== 6'h3F) begin n_bad++; $display("FAIL bounce_mid_state: got %h want %h", key_state, 6'h3F); end
    steps(5);
    key[0] = 1'b1;
    steps(60);
    n_cmp++; if (ev_d.size() != 0) begin n_bad++; $display("FAIL bounce_events: got %0d want 0", ev_d.size()); end
    n_cmp++; if (key_state !== 6'h3F) begin n_bad++; $display("FAIL bounce_end_state: got %h want %h", key_state, 6'h3F); end
  endtask

  task automatic test_press_release();
    int e0;
    logic [4:0] exp_d [2];
    int         exp_t [2];
    ev_d.delete(); ev_t.delete();
    align();
    e0 = cyc;
    exp_d[0] = 5'b01_010; exp_t[0] = e0 + 20;
    exp_d[1] = 5'b11_010; exp_t[1] = e0 + 60;
    key[2] = 1'b0;
    steps(17);
    n_cmp++; if (key_state !== 6'h3F) begin n_bad++; $display("FAIL press_state_before: got %h want %h", key_state, 6'h3F); end
    step();
    n_cmp++; if (key_state !== 6'h3B) begin n_bad++; $display("FAIL press_state_after: got %h want %h", key_state, 6'h3B); end
    steps(22);
    key[2] = 1'b1;
    steps(17);
    n_cmp++; if (key_state !== 6'h3B) begin n_bad++; $display("FAIL release_state_before: got %h want %h", key_state, 6'h3B); end
    step();
    n_cmp++; if (key_state !== 6'h3F) begin n_bad++; $display("FAIL release_state_after: got %h want %h", key_state, 6'h3F); end
    steps(42);
    n_cmp++; if (ev_d.size() != 2) begin n_bad++; $display("FAIL press_release_count: got %0d want 2", ev_d.size()); end
    for (int i = 0; i < 2 && i < ev_d.size(); i++) begin
      n_cmp++; if (ev_d[i] !== exp_d[i]) begin n_bad++; $display("FAIL press_release_data[%0d]: got %b want %b", i, ev_d[i], exp_d[i]); end
      n_cmp++; if (ev_t[i] != exp_t[i]) begin n_bad++; $display("FAIL press_release_time[%0d]: got %0d want %0d", i, ev_t[i], exp_t[i]); end
    end
  endtask

  task automatic test_autorepeat();
    int e0;
    logic [4:0] exp_d [11];
    int         exp_t [11];
    ev_d.delete(); ev_t.delete();
    align();
    e0 = cyc;
    exp_d[0] = 5'b01_001; exp_t[0] = e0 + 20;
    for (int k = 0; k < 9; k++) begin
      exp_d[k + 1] = 5'b10_001;
      exp_t[k + 1] = e0 + 70 + 30 * k;
    end
    exp_d[10] = 5'b11_001; exp_t[10] = e0 + 340;
    key[1] = 1'b0;
    steps(320);
    key[1] = 1'b1;
    steps(60);
    n_cmp++; if (ev_d.size() != 11) begin n_bad++; $display("FAIL autorepeat_count: got %0d want 11", ev_d.size()); end
    for (int i = 0; i < 11 && i < ev_d.size(); i++) begin
      n_cmp++; if (ev_d[i] !== exp_d[i]) begin n_bad++; $display("FAIL autorepeat_data[%0d]: got %b want %b", i, ev_d[i], exp_d[i]); end
      n_cmp++; if (ev_t[i] != exp_t[i]) begin n_bad++; $display("FAIL autorepeat_time[%0d]: got %0d want %0d", i, ev_t[i], exp_t[i]); end
    end
  endtask

  task automatic test_simultaneous();
    int e0;
    logic [4:0] exp_d [4];
    int         exp_t [4];
    ev_d.delete(); ev_t.delete();
    align();
    e0 = cyc;
    exp_d[0] = 5'b01_000; exp_t[0] = e0 + 20;
    exp_d[1] = 5'b01_101; exp_t[1] = e0 + 21;
    exp_d[2] = 5'b11_000; exp_t[2] = e0 + 60;
    exp_d[3] = 5'b11_101; exp_t[3] = e0 + 61;
    key = 6'b01_1110;
    steps(40);
    key = '1;
    steps(60);
    n_cmp++; if (ev_d.size() != 4) begin n_bad++; $display("FAIL simul_count: got %0d want 4", ev_d.size()); end
    for (int i = 0; i < 4 && i < ev_d.size(); i++) begin
      n_cmp++; if (ev_d[i] !== exp_d[i]) begin n_bad++; $display("FAIL simul_data[%0d]: got %b want %b", i, ev_d[i], exp_d[i]); end
      n_cmp++; if (ev_t[i] != exp_t[i]) begin n_bad++; $display("FAIL simul_time[%0d]: got %0d want %0d", i, ev_t[i], exp_t[i]); end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL simul_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_backpressure();
    int e0;
    logic [4:0] exp_d [6];
    int         exp_t [6];
    ev_d.delete(); ev_t.delete();
    evt_ready = 1'b0;
    align();
    e0 = cyc;
    exp_d[0] = 5'b01_011; exp_t[0] = e0 + 345;
    for (int k = 1; k < 5; k++) begin
      exp_d[k] = 5'b10_011;
      exp_t[k] = e0 + 345 + k;
    end
    exp_d[5] = 5'b11_011; exp_t[5] = e0 + 370;
    key[3] = 1'b0;
    steps(25);
    n_cmp++; if (evt_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid_early: got %b want 1", evt_valid); end
    n_cmp++; if (evt_data !== 5'b01_011) begin n_bad++; $display("FAIL bp_head_early: got %b want 01011", evt_data); end
    steps(155);
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL bp_overflow_before: got %b want 0", overflow); end
    n_cmp++; if (evt_data !== 5'b01_011) begin n_bad++; $display("FAIL bp_head_mid: got %b want 01011", evt_data); end
    steps(165);
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL bp_overflow_after: got %b want 1", overflow); end
    n_cmp++; if (evt_data !== 5'b01_011) begin n_bad++; $display("FAIL bp_head_late: got %b want 01011", evt_data); end
    n_cmp++; if (evt_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid_late: got %b want 1", evt_valid); end
    evt_ready = 1'b1;
    steps(5);
    key[3] = 1'b1;
    steps(50);
    n_cmp++; if (ev_d.size() != 6) begin n_bad++; $display("FAIL bp_drain_count: got %0d want 6", ev_d.size()); end
    for (int i = 0; i < 6 && i < ev_d.size(); i++) begin
      n_cmp++; if (ev_d[i] !== exp_d[i]) begin n_bad++; $display("FAIL bp_drain_data[%0d]: got %b want %b", i, ev_d[i], exp_d[i]); end
      n_cmp++; if (ev_t[i] != exp_t[i]) begin n_bad++; $display("FAIL bp_drain_time[%0d]: got %0d want %0d", i, ev_t[i], exp_t[i]); end
    end
  endtask

  task automatic test_reset_mid_hold();
    int e0;
    ev_d.delete(); ev_t.delete();
    evt_ready = 1'b1;
    align();
    e0 = cyc;
    key[4] = 1'b0;
    steps(80);
    n_cmp++; if (ev_d.size() != 2) begin n_bad++; $display("FAIL rmh_pre_count: got %0d want 2", ev_d.size()); end
    if (ev_d.size() >= 2) begin
      n_cmp++; if (ev_d[1] !== 5'b10_100) begin n_bad++; $display("FAIL rmh_pre_repeat: got %b want 10100", ev_d[1]); end
      n_cmp++; if (ev_t[1] != e0 + 70) begin n_bad++; $display("FAIL rmh_pre_time: got %0d want %0d", ev_t[1], e0 + 70); end
    end
    rst = 1'b1;
    step();
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL rmh_valid: got %b want 0", evt_valid); end
    n_cmp++; if (key_state !== 6'h3F) begin n_bad++; $display("FAIL rmh_key_state: got %h want %h", key_state, 6'h3F); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rmh_overflow: got %b want 0", overflow); end
    n_cmp++; if (evt_data !== 5'd0) begin n_bad++; $display("FAIL rmh_evt_data: got %b want 00000", evt_data); end
    steps(2);
    ev_d.delete(); ev_t.delete();
    rst = 1'b0;
    steps(19);
    n_cmp++; if (key_state !== 6'h3F) begin n_bad++; $display("FAIL rmh_state_before: got %h want %h", key_state, 6'h3F); end
    step();
    n_cmp++; if (key_state !== 6'h2F) begin n_bad++; $display("FAIL rmh_state_after: got %h want %h", key_state, 6'h2F); end
    steps(20);
    n_cmp++; if (ev_d.size() != 1) begin n_bad++; $display("FAIL rmh_post_count: got %0d want 1", ev_d.size()); end
    if (ev_d.size() >= 1) begin
      n_cmp++; if (ev_d[0] !== 5'b01_100) begin n_bad++; $display("FAIL rmh_post_press: got %b want 01100", ev_d[0]); end
      n_cmp++; if (ev_t[0] != 22) begin n_bad++; $display("FAIL rmh_post_time: got %0d want 22", ev_t[0]); end
    end
    key[4] = 1'b1;
    steps(40);
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_press_release();
    test_autorepeat();
    test_simultaneous();
    test_backpressure();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
